// File: rtl/chkpt_seq_monitor.sv
// Checkpoint-sequence monitor: synchronises and debounces a status bus, then checks
// that an ordered list of codes appears, each within a per-step cycle budget.
module chkpt_seq_monitor #(
    parameter int WIDTH      = 16,
    parameter int NUM_STEPS  = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT_W  = 24,
    parameter int SW         = $clog2(NUM_STEPS)
) (
    input  logic                       mclk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           status_in,
    input  logic [NUM_STEPS*WIDTH-1:0] exp_codes,
    input  logic [WIDTH-1:0]           fail_code,
    input  logic                       fail_en,
    input  logic [TIMEOUT_W-1:0]       timeout_cyc,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       started,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [SW-1:0]              cur_step,
    output logic [WIDTH-1:0]           last_code
);

    localparam int            CW        = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_STB   = CW'(STABLE_CYC - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PASS,
        ST_FAIL
    } state_e;

    // Front end: synchroniser, hold register and stability counter
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] last_code_q, last_code_d;
    logic             stb;

    // Sequencer state
    state_e                 state_q, state_d;
    logic [SW-1:0]          step_q, step_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic                   started_q, started_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;

    logic [WIDTH-1:0] exp_cur;
    logic             step_match;
    logic             fail_hit;
    logic             expire;
    logic             arm;
    logic             go_idle;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sync1_d     = status_in;
        sync2_d     = sync1_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        if (sync2_q != hold_q) begin
            hold_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        // The counter saturates one past the strobe point, so a held value strobes once.
        stb         = (cnt_q == CNT_STB);
        last_code_d = stb ? hold_q : last_code_q;
    end

    always_comb begin
        exp_cur    = exp_codes[int'(step_q)*WIDTH +: WIDTH];
        step_match = stb && (hold_q == exp_cur);
        fail_hit   = stb && fail_en && (hold_q == fail_code);
        expire     = (timeout_cyc != '0) && (timer_q == timeout_cyc - TIMEOUT_W'(1));
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        timer_d   = timer_q;
        started_d = started_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        arm       = 1'b0;
        go_idle   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                arm = start && !abort;
            end
            ST_WAIT: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (step_match) begin
                    if (step_q == '0) begin
                        started_d = 1'b1;
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        step_d  = step_q + SW'(1);
                        timer_d = '0;
                    end
                end else if (fail_hit) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (expire) begin
                    state_d   = ST_FAIL;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            ST_PASS, ST_FAIL: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (start) begin
                    arm = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Arming and returning to idle both start the next run from a clean slate.
        if (arm || go_idle) begin
            state_d   = arm ? ST_WAIT : ST_IDLE;
            step_d    = '0;
            timer_d   = '0;
            started_d = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
        end

        busy_d = (state_d == ST_WAIT);
    end

    // NOTE: state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            last_code_q <= '0;
            state_q     <= ST_IDLE;
            step_q      <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            started_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            last_code_q <= last_code_d;
            state_q     <= state_d;
            step_q      <= step_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            started_q   <= started_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy      = busy_q;
    assign started   = started_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign cur_step  = step_q;
    assign last_code = last_code_q;

endmodule
